// File: rtl/zeroriscy_defines.sv
// Shared PPU definitions: op width, default lane count, serializer FSM states and the
// posit NaR helper.
package zeroriscy_defines;

    localparam int unsigned PPU_OP_WIDTH    = 4;
    localparam int unsigned PPU_NUM_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ppu_ser_state_e;

    // Posit NaR of the given width: MSB set, all other bits clear.
    function automatic logic [31:0] ppu_nar(input int unsigned width);
        return 32'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/ppu_lane_serializer.sv
// Time-multiplexes one narrow PPU core over the PPU_NUM posit lanes of a 32-bit request.
// Optional watchdog on the core response: define PPU_SERIALIZER_TIMEOUT_EN.
module ppu_lane_serializer
    import zeroriscy_defines::*;
#(
    parameter int unsigned PPU_NUM        = PPU_NUM_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned LANE_W        = 32 / PPU_NUM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ppu_valid_in,
    input  logic [31:0]             ppu_in1,
    input  logic [31:0]             ppu_in2,
    input  logic [PPU_OP_WIDTH-1:0] ppu_op,
    output logic [31:0]             ppu_out,
    output logic                    ppu_valid_o,
    output logic                    core_valid_o,
    output logic [LANE_W-1:0]       core_in1,
    output logic [LANE_W-1:0]       core_in2,
    output logic [PPU_OP_WIDTH-1:0] core_op,
    input  logic [LANE_W-1:0]       core_out_i,
    input  logic                    core_valid_i
`ifdef PPU_SERIALIZER_TIMEOUT_EN
    ,
    output logic                    ppu_timeout_o
`endif
);

    localparam int unsigned LaneIdxW = (PPU_NUM > 1) ? $clog2(PPU_NUM) : 1;
    localparam logic [LaneIdxW-1:0] LastLane = LaneIdxW'(PPU_NUM - 1);

    if (!(PPU_NUM == 1 || PPU_NUM == 2 || PPU_NUM == 4) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ppu_lane_serializer: PPU_NUM must be 1, 2 or 4 and TIMEOUT_CYCLES >= 1");
    end

    ppu_ser_state_e          state_q;
    logic [31:0]             in1_q, in2_q, res_q, ppu_out_q;
    logic [LaneIdxW-1:0]     lane_q, lane_inc;
    logic [LANE_W-1:0]       core_in1_q, core_in2_q, lane_res;
    logic [PPU_OP_WIDTH-1:0] core_op_q;
    logic                    core_valid_q, ppu_valid_q;
    logic                    lane_done;
    logic [31:0]             res_next;

`ifdef PPU_SERIALIZER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] NarWord = ppu_nar(LANE_W);

    logic [CntW-1:0] wd_cnt_q;
    logic            timeout_q;
    logic            wd_expired;

    assign wd_expired    = (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign ppu_timeout_o = timeout_q;
`endif

    always_comb begin
        lane_inc  = lane_q + 1'b1;
        lane_done = core_valid_i;
        lane_res  = core_out_i;
`ifdef PPU_SERIALIZER_TIMEOUT_EN
        // Real data wins if it shows up on the very cycle the watchdog fires.
        lane_done = core_valid_i | wd_expired;
        lane_res  = core_valid_i ? core_out_i : NarWord[LANE_W-1:0];
`endif
        res_next                          = res_q;
        res_next[LANE_W*lane_q +: LANE_W] = lane_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            res_q        <= '0;
            ppu_out_q    <= '0;
            ppu_valid_q  <= 1'b0;
            core_valid_q <= 1'b0;
            core_in1_q   <= '0;
            core_in2_q   <= '0;
            core_op_q    <= '0;
`ifdef PPU_SERIALIZER_TIMEOUT_EN
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            core_valid_q <= 1'b0;
            ppu_valid_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ppu_valid_in) begin
                        in1_q        <= ppu_in1;
                        in2_q        <= ppu_in2;
                        core_op_q    <= ppu_op;
                        lane_q       <= '0;
                        core_in1_q   <= ppu_in1[LANE_W-1:0];
                        core_in2_q   <= ppu_in2[LANE_W-1:0];
                        core_valid_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef PPU_SERIALIZER_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (lane_done) begin
                        res_q <= res_next;
                        if (lane_q == LastLane) begin
                            ppu_out_q   <= res_next;
                            ppu_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            lane_q       <= lane_inc;
                            core_in1_q   <= in1_q[LANE_W*lane_inc +: LANE_W];
                            core_in2_q   <= in2_q[LANE_W*lane_inc +: LANE_W];
                            core_valid_q <= 1'b1;
                            state_q      <= ISSUE;
                        end
                    end
`ifdef PPU_SERIALIZER_TIMEOUT_EN
                    if (wd_expired && !core_valid_i) begin
                        timeout_q <= 1'b1;
                    end else if (!lane_done) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ppu_out      = ppu_out_q;
    assign ppu_valid_o  = ppu_valid_q;
    assign core_valid_o = core_valid_q;
    assign core_in1     = core_in1_q;
    assign core_in2     = core_in2_q;
    assign core_op      = core_op_q;

endmodule

// File: tb/tb_ppu_lane_serializer.sv
// Directed bench for ppu_lane_serializer with a lane-wise adder core of latency 3.
// The watchdog scenario is compiled in only with PPU_SERIALIZER_TIMEOUT_EN.
module tb_ppu_lane_serializer;
    import zeroriscy_defines::*;

    localparam int unsigned N  = 2;
    localparam int unsigned LW = 16;
    localparam int unsigned L  = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    ppu_valid_in = 1'b0;
    logic [31:0]             ppu_in1 = '0;
    logic [31:0]             ppu_in2 = '0;
    logic [PPU_OP_WIDTH-1:0] ppu_op = '0;
    logic [31:0]             ppu_out;
    logic                    ppu_valid_o;
    logic                    core_valid_o;
    logic [LW-1:0]           core_in1, core_in2, core_out_i;
    logic [PPU_OP_WIDTH-1:0] core_op;
    logic                    core_valid_i;
`ifdef PPU_SERIALIZER_TIMEOUT_EN
    logic                    ppu_timeout_o;
`endif

    int total = 0;
    int bad   = 0;

    ppu_lane_serializer #(
        .PPU_NUM        (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ppu_valid_in  (ppu_valid_in),
        .ppu_in1       (ppu_in1),
        .ppu_in2       (ppu_in2),
        .ppu_op        (ppu_op),
        .ppu_out       (ppu_out),
        .ppu_valid_o   (ppu_valid_o),
        .core_valid_o  (core_valid_o),
        .core_in1      (core_in1),
        .core_in2      (core_in2),
        .core_op       (core_op),
        .core_out_i    (core_out_i),
        .core_valid_i  (core_valid_i)
`ifdef PPU_SERIALIZER_TIMEOUT_EN
        ,
        .ppu_timeout_o (ppu_timeout_o)
`endif
    );

    always #5 clk = ~clk;

    // Core model: lane sum after L cycles; mute_en silences lanes whose operand A is 0x7777.
    logic [L-1:0]  vpipe = '0;
    logic [LW-1:0] dpipe [L];
    logic          mute_en = 1'b0;
    logic          spur = 1'b0;

    initial begin
        for (int i = 0; i < int'(L); i++) dpipe[i] = '0;
    end

    always @(posedge clk) begin
        vpipe    <= {vpipe[L-2:0], core_valid_o && !(mute_en && core_in1 == 16'h7777)};
        dpipe[0] <= core_in1 + core_in2;
        for (int i = 1; i < int'(L); i++) dpipe[i] <= dpipe[i-1];
    end

    assign core_valid_i = vpipe[L-1] | spur;
    assign core_out_i   = dpipe[L-1];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Current cycle is the accept cycle; returns cycles until ppu_valid_o, or -1.
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, output int lat);
        ppu_in1      = a;
        ppu_in2      = b;
        ppu_op       = 4'h5;
        ppu_valid_in = 1'b1;
        lat          = -1;
        for (int n = 1; n <= 200; n++) begin
            step();
            if (ppu_valid_o) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat;
    int issues;
    int resp_cnt;
    int iss_cnt;
    logic [15:0] iss_a [2];
    logic [15:0] iss_b [2];

    initial begin
        // 1: reset then a single request
        step();
        check_eq("rst_ppu_out", ppu_out, 32'h0);
        check_eq("rst_ppu_valid", 32'(ppu_valid_o), 32'h0);
        check_eq("rst_core_valid", 32'(core_valid_o), 32'h0);
        check_eq("rst_core_in1", 32'(core_in1), 32'h0);
        check_eq("rst_core_in2", 32'(core_in2), 32'h0);
        check_eq("rst_core_op", 32'(core_op), 32'h0);
`ifdef PPU_SERIALIZER_TIMEOUT_EN
        check_eq("rst_timeout", 32'(ppu_timeout_o), 32'h0);
`endif
        rst = 1'b0;
        step();
        run_req(32'h4000_3800, 32'h1111_2222, lat);
        check_eq("t1_latency", 32'(lat), 32'd9);
        check_eq("t1_result", ppu_out, 32'h5111_5A22);

        // 2: valid held high through the response -> new request
        ppu_in1 = 32'h0001_0001;
        ppu_in2 = 32'h0001_0001;
        step();
        check_eq("t1_pulse_width", 32'(ppu_valid_o), 32'h0);
        run_req(32'h0001_0001, 32'h0001_0001, lat);
        check_eq("t2_latency", 32'(lat), 32'd9);
        check_eq("t2_result", ppu_out, 32'h0002_0002);
        ppu_valid_in = 1'b0;
        step();
        check_eq("t2_pulse_width", 32'(ppu_valid_o), 32'h0);
        step();

        // 3: operands scrambled every cycle after accept
        ppu_in1      = 32'h4000_3800;
        ppu_in2      = 32'h1111_2222;
        ppu_op       = 4'h3;
        ppu_valid_in = 1'b1;
        lat          = -1;
        issues       = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (core_valid_o) begin
                if (issues < 2) begin
                    iss_a[issues] = core_in1;
                    iss_b[issues] = core_in2;
                end
                issues++;
                check_eq("t3_core_op", 32'(core_op), 32'h3);
            end
            if (ppu_valid_o) begin
                lat = n;
                break;
            end
            ppu_in1 = $urandom;
            ppu_in2 = $urandom;
            ppu_op  = 4'($urandom);
        end
        ppu_valid_in = 1'b0;
        check_eq("t3_issue_count", 32'(issues), 32'd2);
        check_eq("t3_lane0_in1", 32'(iss_a[0]), 32'h3800);
        check_eq("t3_lane0_in2", 32'(iss_b[0]), 32'h2222);
        check_eq("t3_lane1_in1", 32'(iss_a[1]), 32'h4000);
        check_eq("t3_latency", 32'(lat), 32'd9);
        check_eq("t3_result", ppu_out, 32'h5111_5A22);
        step();

        // 4: reset in WAIT of lane 1, the late core answer must be dropped
        ppu_in1      = 32'h0003_0005;
        ppu_in2      = 32'h0004_0006;
        ppu_valid_in = 1'b1;
        issues       = 0;
        for (int n = 0; n < 40 && issues < 2; n++) begin
            step();
            if (core_valid_o) issues++;
        end
        check_eq("t4_reached_lane1", 32'(issues), 32'd2);
        ppu_valid_in = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        resp_cnt = 0;
        iss_cnt  = 0;
        for (int n = 0; n < 10; n++) begin
            if (ppu_valid_o) resp_cnt++;
            if (core_valid_o) iss_cnt++;
            step();
        end
        check_eq("t4_no_resp", 32'(resp_cnt), 32'd0);
        check_eq("t4_no_issue", 32'(iss_cnt), 32'd0);
        check_eq("t4_ppu_out", ppu_out, 32'h0);
        check_eq("t4_state", 32'(dut.state_q), 32'(IDLE));

        // 5: spurious core_valid_i in IDLE
        run_req(32'h0010_0020, 32'h0001_0002, lat);
        ppu_valid_in = 1'b0;
        check_eq("t5_pre_result", ppu_out, 32'h0011_0022);
        step();
        resp_cnt = 0;
        iss_cnt  = 0;
        for (int n = 0; n < 6; n++) begin
            spur = (n != 1);
            step();
            if (ppu_valid_o) resp_cnt++;
            if (core_valid_o) iss_cnt++;
        end
        spur = 1'b0;
        step();
        check_eq("t5_no_resp", 32'(resp_cnt), 32'd0);
        check_eq("t5_no_issue", 32'(iss_cnt), 32'd0);
        check_eq("t5_ppu_out_held", ppu_out, 32'h0011_0022);
        check_eq("t5_state", 32'(dut.state_q), 32'(IDLE));

        // Lane wrap must not carry into the neighbouring lane
        run_req(32'hFFFF_8000, 32'h0001_8000, lat);
        ppu_valid_in = 1'b0;
        check_eq("lane_wrap_latency", 32'(lat), 32'd9);
        check_eq("lane_wrap_result", ppu_out, 32'h0000_0000);
        step();

`ifdef PPU_SERIALIZER_TIMEOUT_EN
        // 6: core never answers lane 1
        check_eq("t6_timeout_clear", 32'(ppu_timeout_o), 32'h0);
        mute_en = 1'b1;
        run_req(32'h7777_0001, 32'h0000_0002, lat);
        ppu_valid_in = 1'b0;
        mute_en      = 1'b0;
        check_eq("t6_resp_seen", 32'(lat > 0), 32'h1);
        check_eq("t6_result", ppu_out, 32'h8000_0003);
        check_eq("t6_timeout_set", 32'(ppu_timeout_o), 32'h1);
        step();
        run_req(32'h0001_0001, 32'h0002_0002, lat);
        ppu_valid_in = 1'b0;
        check_eq("t6_after_result", ppu_out, 32'h0003_0003);
        check_eq("t6_timeout_sticky", 32'(ppu_timeout_o), 32'h1);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
